// File: rtl/serial_adder6.sv
// serial_adder6: bit-serial 6-bit adder. Each operation takes one IDLE->RUN
// handshake, six RUN cycles (one full-adder bit per cycle, LSB first) and
// one DONE cycle.
// Optional feature macro: SERIAL_ADDER6_OVF_EN enables the signed overflow
// flag. When it is undefined, ovf is tied to 0.
module serial_adder6 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] a,
    input  logic [5:0] b,
    output logic       busy,
    output logic       done,
    output logic [5:0] sum,
    output logic       carry_out,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [5:0] a_sh;
    logic [5:0] b_sh;
    logic [4:0] psum;    // result bits 0..4 collected so far, MSB-side fill
    logic       c;
    logic [2:0] cnt;

    logic       bit_s;
    logic       c_next;
    logic       last;

    // One full-adder slice on the operand LSBs
    always_comb begin
        bit_s  = a_sh[0] ^ b_sh[0] ^ c;
        c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        last   = (cnt == 3'd5);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand shift registers, running carry, counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            psum      <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        psum <= '0;
                        c    <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= {1'b0, a_sh[5:1]};
                    b_sh <= {1'b0, b_sh[5:1]};
                    psum <= {bit_s, psum[4:1]};
                    c    <= c_next;
                    cnt  <= cnt + 3'd1;
                    // Visible result changes only when the final bit is known
                    if (last) begin
                        sum       <= {bit_s, psum};
                        carry_out <= c_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER6_OVF_EN
    logic ovf_r;

    // Signed overflow: carry into bit 5 differs from carry out of bit 5
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_r <= c ^ c_next;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule
